snake_step_scheduler: RTL
=========================

// Module: snake_step_scheduler
// PURPOSE
//  Game-flow controller and move scheduler for the snake datapath. Owns the play FSM, debounces the centre
//  button into restart/pause events, and issues the single-cycle step_tick that advances the snake. The
//  move interval shrinks as score rises. Sits between board I/O and the snake datapath.
// PARAMETERS
//  CNT_W            27          width of interval counter and interval values
//  BASE_INTERVAL    50_000_000  cycles per move at level 0
//  MIN_INTERVAL     10_000_000  floor on cycles per move
//  INTERVAL_DEC     5_000_000   interval reduction per level
//  POINTS_PER_LEVEL 5           score points per level
//  MAX_LEVEL        15          level saturation value (fits level port)
//  DEBOUNCE_CYCLES  1_000_000   stable-sample count for button acceptance
// PORTS
//  clk           in   1      system clock, 100 MHz
//  rst           in   1      synchronous, active-high reset
//  button        in   1      raw centre button, asynchronous
//  game_over_in  in   1      datapath collision flag, level
//  score_in      in   16     datapath score, binary
//  step_tick     out  1      one-cycle move strobe to datapath
//  restart       out  1      one-cycle strobe: datapath reinitialises snake/score
//  running       out  1      high in RUN
//  paused        out  1      high in PAUSE; constant 0 without SNAKE_PAUSE_EN
//  state         out  2      00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
//  level         out  4      current speed level
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, interval=BASE_INTERVAL, level=0, all strobes/flags 0. Also applies mid-game.
//  - Button path: 2-FF sync -> debounce. The debounced level changes after the synced input differs from it
//    for DEBOUNCE_CYCLES consecutive cycles. press = debounced rising edge, 1 cycle.
//  - IDLE: no ticks. press -> RUN, restart=1 in the transition cycle, counter=0.
//  - RUN: counter increments each cycle. When counter==interval-1: step_tick=1, counter->0, interval reloads.
//    First tick occurs interval cycles after RUN entry. Interval is latched only at reload or RUN entry, so a
//    period in progress is never shortened.
//  - RUN, game_over_in=1 -> OVER. This takes priority over both tick and press in the same cycle; both are suppressed.
//  - RUN, press: PAUSE with SNAKE_PAUSE_EN. Without it: restart=1, counter=0, stay RUN.
//  - PAUSE: counter frozen, no ticks. press -> RUN, counting resumes from the frozen value (no restart).
//  - OVER: no ticks. press -> RUN with restart=1, counter=0.
//  - level = min(score_in / POINTS_PER_LEVEL, MAX_LEVEL), registered with 1-cycle latency.
//    Target interval = max(BASE_INTERVAL - level*INTERVAL_DEC, MIN_INTERVAL). Compute at CNT_W+4 bits, no underflow.
//  - step_tick and restart are never high in the same cycle.
// CONFIGURATION
//  SNAKE_PAUSE_EN defined: PAUSE state reachable, press in RUN toggles pause, paused output live.
//  Undefined: PAUSE state absent, press in RUN restarts the game, paused tied 0.
// STRUCTURE
//  Package snake_pkg: state encodings (ST_IDLE/RUN/PAUSE/OVER) and shared DIR_* codes.
//  It also holds the grid constants reused by the datapath.
//  Sub-module btn_debounce (synchroniser + debounce counter + edge pulse), parameterised by DEBOUNCE_CYCLES.
// TESTING  (override: BASE=20, MIN=8, DEC=4, PPL=2, DEBOUNCE=4)
//  - rst, then button high 10 cycles -> one press, one restart pulse, state 00->01; first tick 20 cycles later.
//  - RUN at score 0 -> ticks every 20 cycles. score_in=4 -> level 2, period 12 from next reload.
//    score_in=40 -> level 15, period clamps to 8.
//  - Button glitch 3 cycles high -> no press, no state change.
//  - game_over_in asserted on the cycle a tick is due, with press -> no tick, state 11. Later press -> restart, 01.
//  - SNAKE_PAUSE_EN: press at counter=7 -> PAUSE, no ticks for 100 cycles; press -> tick 13 cycles after resume.
//  - rst asserted in RUN mid-period -> next cycle state 00, step_tick/restart 0, level 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake definitions: play-state encodings, direction codes and grid constants.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  localparam int GRID_W = 32;
  localparam int GRID_H = 24;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-count debounce, one-cycle press on debounced rise.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_a, sync_b;
  logic          deb, deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      deb    <= 1'b0;
      deb_d  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_a <= button;
      sync_b <= sync_a;
      deb_d  <= deb;
      // any agreeing sample restarts the stability count
      if (sync_b != deb) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb <= sync_b;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = deb & ~deb_d;

endmodule

// File: rtl/snake_step_scheduler.sv
// Snake play FSM and move scheduler; interval shrinks with level.
// Build option SNAKE_PAUSE_EN: press in RUN pauses instead of restarting.
module snake_step_scheduler
  import snake_pkg::*;
#(
  parameter int CNT_W            = 27,
  parameter int BASE_INTERVAL    = 50_000_000,
  parameter int MIN_INTERVAL     = 10_000_000,
  parameter int INTERVAL_DEC     = 5_000_000,
  parameter int POINTS_PER_LEVEL = 5,
  parameter int MAX_LEVEL        = 15,
  parameter int DEBOUNCE_CYCLES  = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic        game_over_in,
  input  logic [15:0] score_in,
  output logic        step_tick,
  output logic        restart,
  output logic        running,
  output logic        paused,
  output logic [1:0]  state,
  output logic [3:0]  level
);

  localparam int IW = CNT_W + 4;

  state_e           st;
  logic             press;
  logic [CNT_W-1:0] counter, interval, target;
  logic [15:0]      lvl_q;
  logic [3:0]       lvl_next;
  logic [IW-1:0]    dec_w, diff_w;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .press  (press)
  );

  assign lvl_q    = score_in / 16'(POINTS_PER_LEVEL);
  assign lvl_next = (lvl_q > 16'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : lvl_q[3:0];

  // widened so a large level clamps to the floor instead of wrapping
  assign dec_w  = IW'(level) * IW'(INTERVAL_DEC);
  assign diff_w = IW'(BASE_INTERVAL) - dec_w;
  assign target = (dec_w >= IW'(BASE_INTERVAL) || diff_w < IW'(MIN_INTERVAL))
                  ? CNT_W'(MIN_INTERVAL) : diff_w[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      counter   <= '0;
      interval  <= CNT_W'(BASE_INTERVAL);
      level     <= '0;
      step_tick <= 1'b0;
      restart   <= 1'b0;
    end else begin
      level     <= lvl_next;
      step_tick <= 1'b0;
      restart   <= 1'b0;
      case (st)
        ST_IDLE, ST_OVER: begin
          if (press) begin
            st       <= ST_RUN;
            restart  <= 1'b1;
            counter  <= '0;
            interval <= target;
          end
        end
        ST_RUN: begin
          if (game_over_in) begin
            st <= ST_OVER;
          end else if (press) begin
`ifdef SNAKE_PAUSE_EN
            st <= ST_PAUSE;
`else
            restart  <= 1'b1;
            counter  <= '0;
            interval <= target;
`endif
          end else if (counter == interval - 1'b1) begin
            step_tick <= 1'b1;
            counter   <= '0;
            interval  <= target;
          end else begin
            counter <= counter + 1'b1;
          end
        end
`ifdef SNAKE_PAUSE_EN
        ST_PAUSE: begin
          if (press) st <= ST_RUN;
        end
`endif
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign state   = st;
  assign running = (st == ST_RUN);
`ifdef SNAKE_PAUSE_EN
  assign paused  = (st == ST_PAUSE);
`else
  assign paused  = 1'b0;
`endif

endmodule
